// File: rtl/id_stage_if.sv
// Pipeline-side bus of the decode stage: IF/ID handshake in, ID/EX slot out.
// The master modport is the decode stage; slave is its environment.
interface id_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            if_valid_i;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     inst_i;
  logic            id_ready_o;

  logic            ex_ready_i;
  logic            ex_valid_o;
  logic [3:0]      aluop_o;
  logic [XLEN-1:0] reg1_o;
  logic [XLEN-1:0] reg2_o;
  logic            wreg_o;
  logic [4:0]      wd_o;
  logic [XLEN-1:0] pc_o;
  logic            illegal_o;

  modport master (
    input  if_valid_i, pc_i, inst_i, ex_ready_i,
    output id_ready_o, ex_valid_o, aluop_o, reg1_o, reg2_o,
           wreg_o, wd_o, pc_o, illegal_o
  );

  modport slave (
    output if_valid_i, pc_i, inst_i, ex_ready_i,
    input  id_ready_o, ex_valid_o, aluop_o, reg1_o, reg2_o,
           wreg_o, wd_o, pc_o, illegal_o
  );
endinterface

// File: rtl/id_stage.sv
// RV32I integer-ALU decode stage with regfile read, EX/MEM forwarding,
// load-use interlock and a single registered ID/EX slot.
module id_stage #(
  parameter int unsigned XLEN   = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  id_stage_if.master      bus,
  output logic            reg1_read_o,
  output logic            reg2_read_o,
  output logic [4:0]      reg1_addr_o,
  output logic [4:0]      reg2_addr_o,
  input  logic [XLEN-1:0] reg1_data_i,
  input  logic [XLEN-1:0] reg2_data_i,
  input  logic            ex_wreg_i,
  input  logic [4:0]      ex_wd_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            ex_is_load_i,
  input  logic            mem_wreg_i,
  input  logic [4:0]      mem_wd_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic            flush_i
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_NOP  = 4'd15
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            hazard;

  alu_op_e         dec_op;
  logic            dec_re1;
  logic            dec_re2;
  logic            dec_legal;
  logic            dec_wreg;
  logic [XLEN-1:0] dec_reg1;
  logic [XLEN-1:0] dec_reg2;

  slot_e           slot_q;
  alu_op_e         aluop_q;
  logic [XLEN-1:0] reg1_q;
  logic [XLEN-1:0] reg2_q;
  logic [XLEN-1:0] pc_q;
  logic            wreg_q;
  logic [4:0]      wd_q;
  logic            illegal_q;

  assign opcode = bus.inst_i[6:0];
  assign funct3 = bus.inst_i[14:12];
  assign funct7 = bus.inst_i[31:25];
  assign rd     = bus.inst_i[11:7];
  assign imm_i  = XLEN'($signed(bus.inst_i[31:20]));
  assign imm_u  = XLEN'($signed({bus.inst_i[31:12], 12'b0}));
  assign shamt  = XLEN'(bus.inst_i[24:20]);

  assign reg1_addr_o = bus.inst_i[19:15];
  assign reg2_addr_o = bus.inst_i[24:20];
  assign reg1_read_o = dec_re1;
  assign reg2_read_o = dec_re2;

  generate
    if (FWD_EN) begin : g_fwd
      // EX is the younger producer, so it shadows MEM for the same register.
      always_comb begin
        if (reg1_addr_o == '0)                             src1 = '0;
        else if (ex_wreg_i && (ex_wd_i == reg1_addr_o))    src1 = ex_wdata_i;
        else if (mem_wreg_i && (mem_wd_i == reg1_addr_o))  src1 = mem_wdata_i;
        else                                               src1 = reg1_data_i;
      end

      always_comb begin
        if (reg2_addr_o == '0)                             src2 = '0;
        else if (ex_wreg_i && (ex_wd_i == reg2_addr_o))    src2 = ex_wdata_i;
        else if (mem_wreg_i && (mem_wd_i == reg2_addr_o))  src2 = mem_wdata_i;
        else                                               src2 = reg2_data_i;
      end

      assign hazard = bus.if_valid_i && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                      ((dec_re1 && (ex_wd_i == reg1_addr_o)) ||
                       (dec_re2 && (ex_wd_i == reg2_addr_o)));
    end else begin : g_interlock
      logic pend1;
      logic pend2;

      assign src1 = (reg1_addr_o == '0) ? '0 : reg1_data_i;
      assign src2 = (reg2_addr_o == '0) ? '0 : reg2_data_i;

      assign pend1 = (reg1_addr_o != '0) &&
                     ((ex_wreg_i && (ex_wd_i == reg1_addr_o)) ||
                      (mem_wreg_i && (mem_wd_i == reg1_addr_o)));
      assign pend2 = (reg2_addr_o != '0) &&
                     ((ex_wreg_i && (ex_wd_i == reg2_addr_o)) ||
                      (mem_wreg_i && (mem_wd_i == reg2_addr_o)));

      assign hazard = (dec_re1 && pend1) || (dec_re2 && pend2);
    end
  endgenerate

  always_comb begin
    dec_op    = ALU_NOP;
    dec_re1   = 1'b0;
    dec_re2   = 1'b0;
    dec_legal = 1'b0;
    dec_reg1  = '0;
    dec_reg2  = '0;

    case (opcode)
      OPC_OP_IMM: begin
        dec_re1   = 1'b1;
        dec_legal = 1'b1;
        dec_reg1  = src1;
        dec_reg2  = imm_i;
        case (funct3)
          3'b000:  dec_op = ALU_ADD;
          3'b010:  dec_op = ALU_SLT;
          3'b011:  dec_op = ALU_SLTU;
          3'b100:  dec_op = ALU_XOR;
          3'b110:  dec_op = ALU_OR;
          3'b111:  dec_op = ALU_AND;
          3'b001: begin
            dec_reg2 = shamt;
            if (funct7 == F7_BASE) dec_op = ALU_SLL;
            else                   dec_legal = 1'b0;
          end
          default: begin
            dec_reg2 = shamt;
            if (funct7 == F7_BASE)     dec_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_op = ALU_SRA;
            else                       dec_legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        dec_re1   = 1'b1;
        dec_re2   = 1'b1;
        dec_legal = 1'b1;
        dec_reg1  = src1;
        dec_reg2  = src2;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec_op = ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b000)) begin
          dec_op = ALU_SUB;
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
          dec_op = ALU_SRA;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_ADD;
        dec_reg2  = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_op    = ALU_ADD;
        dec_reg1  = bus.pc_i;
        dec_reg2  = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase

    // Unsupported encodings must not read registers, so they never stall.
    if (!dec_legal) begin
      dec_op   = ALU_NOP;
      dec_re1  = 1'b0;
      dec_re2  = 1'b0;
      dec_reg1 = '0;
      dec_reg2 = '0;
    end
  end

  assign dec_wreg = dec_legal && (rd != '0);

  assign bus.id_ready_o = flush_i ||
                          (!hazard && ((slot_q == SLOT_EMPTY) || bus.ex_ready_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q    <= SLOT_EMPTY;
      aluop_q   <= ALU_NOP;
      reg1_q    <= '0;
      reg2_q    <= '0;
      pc_q      <= '0;
      wreg_q    <= 1'b0;
      wd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      slot_q    <= SLOT_EMPTY;
      aluop_q   <= ALU_NOP;
      wreg_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if ((slot_q == SLOT_FULL) && !bus.ex_ready_i) begin
      // Held operands keep their captured values; no re-forwarding.
      slot_q <= slot_q;
    end else if (bus.if_valid_i && !hazard) begin
      slot_q    <= SLOT_FULL;
      aluop_q   <= dec_op;
      reg1_q    <= dec_reg1;
      reg2_q    <= dec_reg2;
      pc_q      <= bus.pc_i;
      wreg_q    <= dec_wreg;
      wd_q      <= rd;
      illegal_q <= !dec_legal;
    end else begin
      slot_q    <= SLOT_EMPTY;
      aluop_q   <= ALU_NOP;
      wreg_q    <= 1'b0;
      illegal_q <= 1'b0;
    end
  end

  assign bus.ex_valid_o = (slot_q == SLOT_FULL);
  assign bus.aluop_o    = aluop_q;
  assign bus.reg1_o     = reg1_q;
  assign bus.reg2_o     = reg2_q;
  assign bus.pc_o       = pc_q;
  assign bus.wreg_o     = wreg_q;
  assign bus.wd_o       = wd_q;
  assign bus.illegal_o  = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: one forwarding instance and one interlock-only
// instance share the regfile/write-back inputs but are exercised in turn.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) bus_a ();
  id_stage_if #(.XLEN(32)) bus_b ();

  logic        a_re1, a_re2, b_re1, b_re2;
  logic [4:0]  a_ra1, a_ra2, b_ra1, b_ra2;
  logic [31:0] rf1, rf2;
  logic        ex_wreg, ex_load, mem_wreg, flush;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, mem_wdata;

  id_stage #(.XLEN(32), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .bus(bus_a),
    .reg1_read_o(a_re1), .reg2_read_o(a_re2),
    .reg1_addr_o(a_ra1), .reg2_addr_o(a_ra2),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_load),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .flush_i(flush)
  );

  id_stage #(.XLEN(32), .FWD_EN(1'b0)) u_ilk (
    .clk(clk), .rst(rst), .bus(bus_b),
    .reg1_read_o(b_re1), .reg2_read_o(b_re2),
    .reg1_addr_o(b_ra1), .reg2_addr_o(b_ra2),
    .reg1_data_i(rf1), .reg2_data_i(rf2),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_load),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .flush_i(flush)
  );

  typedef struct {
    logic [3:0]  aluop;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] pc;
    logic        ill;
    bit          chk_ops;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_tests;
  int   n_fail;

  localparam logic [31:0] I_ADD = 32'h002081B3;

  function automatic exp_t mk(input logic [3:0] aluop, input logic [31:0] r1, input logic [31:0] r2,
                              input logic wreg, input logic [4:0] wd, input logic [31:0] pc,
                              input logic ill, input bit chk_ops);
    exp_t e;
    e.aluop = aluop; e.r1 = r1; e.r2 = r2; e.wreg = wreg;
    e.wd = wd; e.pc = pc; e.ill = ill; e.chk_ops = chk_ops;
    return e;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, 32'(act), 32'(exp));
  endtask

  task automatic cmp_slot(input string tag, input exp_t e, input logic [3:0] aluop,
                          input logic [31:0] r1, input logic [31:0] r2, input logic wreg,
                          input logic [4:0] wd, input logic [31:0] pc, input logic ill);
    check32({tag, "_aluop"}, 32'(aluop), 32'(e.aluop));
    check1({tag, "_wreg"}, wreg, e.wreg);
    check32({tag, "_pc"}, pc, e.pc);
    check1({tag, "_illegal"}, ill, e.ill);
    if (e.chk_ops) begin
      check32({tag, "_reg1"}, r1, e.r1);
      check32({tag, "_reg2"}, r2, e.r2);
      check32({tag, "_wd"}, 32'(wd), 32'(e.wd));
    end
  endtask

  // A slot counts as delivered on the cycle EX accepts it.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst === 1'b1 && bus_a.ex_valid_o === 1'b1 && bus_a.ex_ready_i === 1'b1) begin
      if (sb_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: slot pc 0x%08h delivered, expected no slot", bus_a.pc_o);
      end else begin
        e = sb_a.pop_front();
        cmp_slot($sformatf("a_pc%0h", e.pc), e, bus_a.aluop_o, bus_a.reg1_o, bus_a.reg2_o,
                 bus_a.wreg_o, bus_a.wd_o, bus_a.pc_o, bus_a.illegal_o);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst === 1'b1 && bus_b.ex_valid_o === 1'b1 && bus_b.ex_ready_i === 1'b1) begin
      if (sb_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: slot pc 0x%08h delivered, expected no slot", bus_b.pc_o);
      end else begin
        e = sb_b.pop_front();
        cmp_slot($sformatf("b_pc%0h", e.pc), e, bus_b.aluop_o, bus_b.reg1_o, bus_b.reg2_o,
                 bus_b.wreg_o, bus_b.wd_o, bus_b.pc_o, bus_b.illegal_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit use_b, input logic [31:0] pc, input logic [31:0] inst,
                       input exp_t e, input string name);
    if (use_b) begin
      bus_b.if_valid_i = 1'b1; bus_b.pc_i = pc; bus_b.inst_i = inst;
      #1;
      check1({name, "_ready"}, bus_b.id_ready_o, 1'b1);
      sb_b.push_back(e);
    end else begin
      bus_a.if_valid_i = 1'b1; bus_a.pc_i = pc; bus_a.inst_i = inst;
      #1;
      check1({name, "_ready"}, bus_a.id_ready_o, 1'b1);
      sb_a.push_back(e);
    end
    tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0;
    bus_a.if_valid_i = 1'b0; bus_a.pc_i = '0; bus_a.inst_i = '0; bus_a.ex_ready_i = 1'b1;
    bus_b.if_valid_i = 1'b0; bus_b.pc_i = '0; bus_b.inst_i = '0; bus_b.ex_ready_i = 1'b1;
    rf1 = '0; rf2 = '0; flush = 1'b0;
    ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0; ex_load = 1'b0;
    mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;

    #12;
    check1("rst_a_valid", bus_a.ex_valid_o, 1'b0);
    check32("rst_a_aluop", 32'(bus_a.aluop_o), 32'd15);
    check32("rst_a_reg1", bus_a.reg1_o, 32'd0);
    check32("rst_a_reg2", bus_a.reg2_o, 32'd0);
    check32("rst_a_pc", bus_a.pc_o, 32'd0);
    check1("rst_a_wreg", bus_a.wreg_o, 1'b0);
    check32("rst_a_wd", 32'(bus_a.wd_o), 32'd0);
    check1("rst_a_illegal", bus_a.illegal_o, 1'b0);
    check1("rst_b_valid", bus_b.ex_valid_o, 1'b0);
    check32("rst_b_aluop", 32'(bus_b.aluop_o), 32'd15);
    tick();
    rst = 1'b1;

    // Back-to-back decode with forwarding on the FWD_EN=1 instance.
    issue(1'b0, 32'h100, 32'h0FF06093, mk(4'd8, 32'h0, 32'hFF, 1'b1, 5'd1, 32'h100, 1'b0, 1'b1), "ori");
    check1("ori_re1", a_re1, 1'b1);
    check1("ori_re2", a_re2, 1'b0);

    ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'd5;
    mem_wreg = 1'b1; mem_wd = 5'd2; mem_wdata = 32'd7;
    issue(1'b0, 32'h104, I_ADD, mk(4'd0, 32'd5, 32'd7, 1'b1, 5'd3, 32'h104, 1'b0, 1'b1), "add_fwd");
    check32("add_raddr2", 32'(a_ra2), 32'd2);

    mem_wd = 5'd1; rf2 = 32'h22;
    issue(1'b0, 32'h108, I_ADD, mk(4'd0, 32'd5, 32'h22, 1'b1, 5'd3, 32'h108, 1'b0, 1'b1), "add_prio");

    ex_wreg = 1'b0; mem_wreg = 1'b0; rf1 = 32'h8000_0000; rf2 = '0;
    issue(1'b0, 32'h10C, 32'h4040D313, mk(4'd7, 32'h8000_0000, 32'd4, 1'b1, 5'd6, 32'h10C, 1'b0, 1'b1), "srai");
    issue(1'b0, 32'h110, 32'h123452B7, mk(4'd0, 32'h0, 32'h1234_5000, 1'b1, 5'd5, 32'h110, 1'b0, 1'b1), "lui");
    check1("lui_re1", a_re1, 1'b0);
    check1("lui_re2", a_re2, 1'b0);
    issue(1'b0, 32'h114, 32'h80000397, mk(4'd0, 32'h114, 32'h8000_0000, 1'b1, 5'd7, 32'h114, 1'b0, 1'b1), "auipc");
    issue(1'b0, 32'h118, 32'h0000007F, mk(4'd15, 32'h0, 32'h0, 1'b0, 5'd0, 32'h118, 1'b1, 1'b0), "ill_opc");
    issue(1'b0, 32'h11C, 32'h40209233, mk(4'd15, 32'h0, 32'h0, 1'b0, 5'd0, 32'h11C, 1'b1, 1'b0), "ill_f7");
    rf1 = 32'd3; rf2 = 32'd4;
    issue(1'b0, 32'h120, 32'h00208033, mk(4'd0, 32'd3, 32'd4, 1'b0, 5'd0, 32'h120, 1'b0, 1'b1), "add_x0");
    issue(1'b0, 32'h124, 32'h402081B3, mk(4'd1, 32'd3, 32'd4, 1'b1, 5'd3, 32'h124, 1'b0, 1'b1), "sub");

    // Load-use: one bubble, then the consumer picks the value up from MEM.
    ex_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'h55; rf1 = '0; rf2 = '0;
    bus_a.if_valid_i = 1'b1; bus_a.pc_i = 32'h200; bus_a.inst_i = I_ADD;
    #1;
    check1("lu_ready_stall", bus_a.id_ready_o, 1'b0);
    tick();
    check1("lu_bubble_valid", bus_a.ex_valid_o, 1'b0);
    check32("lu_bubble_aluop", 32'(bus_a.aluop_o), 32'd15);
    ex_load = 1'b0; ex_wreg = 1'b0; mem_wreg = 1'b1; mem_wd = 5'd1; mem_wdata = 32'h55;
    issue(1'b0, 32'h200, I_ADD, mk(4'd0, 32'h55, 32'h0, 1'b1, 5'd3, 32'h200, 1'b0, 1'b1), "lu_add");
    mem_wreg = 1'b0;

    // Backpressure: slot held for three cycles, next instruction waits.
    issue(1'b0, 32'h300, 32'hFFF00413, mk(4'd0, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd8, 32'h300, 1'b0, 1'b1), "addi_neg");
    bus_a.ex_ready_i = 1'b0; bus_a.pc_i = 32'h304; bus_a.inst_i = 32'h00106493;
    #1;
    for (int k = 0; k < 3; k++) begin
      check1($sformatf("bp_ready_%0d", k), bus_a.id_ready_o, 1'b0);
      @(negedge clk);
      check1($sformatf("bp_valid_%0d", k), bus_a.ex_valid_o, 1'b1);
      check32($sformatf("bp_reg2_%0d", k), bus_a.reg2_o, 32'hFFFF_FFFF);
      check32($sformatf("bp_pc_%0d", k), bus_a.pc_o, 32'h300);
      tick();
    end
    bus_a.ex_ready_i = 1'b1;
    issue(1'b0, 32'h304, 32'h00106493, mk(4'd8, 32'h0, 32'h1, 1'b1, 5'd9, 32'h304, 1'b0, 1'b1), "bp_resume");

    // Flush beats both backpressure and a load-use hazard; the held ORI is dropped.
    bus_a.ex_ready_i = 1'b0; flush = 1'b1;
    ex_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd1;
    bus_a.if_valid_i = 1'b1; bus_a.pc_i = 32'h308; bus_a.inst_i = I_ADD;
    #1;
    check1("flush_ready", bus_a.id_ready_o, 1'b1);
    void'(sb_a.pop_back());
    tick();
    check1("flush_valid", bus_a.ex_valid_o, 1'b0);
    check32("flush_aluop", 32'(bus_a.aluop_o), 32'd15);
    check1("flush_wreg", bus_a.wreg_o, 1'b0);
    check1("flush_illegal", bus_a.illegal_o, 1'b0);
    flush = 1'b0; ex_load = 1'b0; ex_wreg = 1'b0; bus_a.ex_ready_i = 1'b1;

    // Asynchronous reset while a slot is held.
    issue(1'b0, 32'h400, 32'h0F007513, mk(4'd9, 32'h0, 32'hF0, 1'b1, 5'd10, 32'h400, 1'b0, 1'b1), "andi");
    bus_a.ex_ready_i = 1'b0; bus_a.if_valid_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check1("rsthold_valid", bus_a.ex_valid_o, 1'b0);
    check32("rsthold_aluop", 32'(bus_a.aluop_o), 32'd15);
    check32("rsthold_pc", bus_a.pc_o, 32'h0);
    void'(sb_a.pop_back());
    tick();
    rst = 1'b1; bus_a.ex_ready_i = 1'b1;
    tick();

    // Interlock-only instance: MEM-pending source stalls until it retires.
    mem_wreg = 1'b1; mem_wd = 5'd2; mem_wdata = 32'h77; rf1 = 32'h11; rf2 = 32'h22;
    bus_b.if_valid_i = 1'b1; bus_b.pc_i = 32'h500; bus_b.inst_i = I_ADD;
    #1;
    check1("ilk_ready_stall", bus_b.id_ready_o, 1'b0);
    tick();
    check1("ilk_bubble_valid", bus_b.ex_valid_o, 1'b0);
    mem_wreg = 1'b0;
    issue(1'b1, 32'h500, I_ADD, mk(4'd0, 32'h11, 32'h22, 1'b1, 5'd3, 32'h500, 1'b0, 1'b1), "ilk_add");
    ex_wreg = 1'b1; ex_wd = 5'd0;
    issue(1'b1, 32'h504, 32'h00500213, mk(4'd0, 32'h0, 32'd5, 1'b1, 5'd4, 32'h504, 1'b0, 1'b1), "ilk_x0");
    ex_wreg = 1'b0;
    bus_b.if_valid_i = 1'b0;

    repeat (3) tick();
    check32("a_sb_drained", 32'(sb_a.size()), 32'd0);
    check32("b_sb_drained", 32'(sb_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised RV32I decode stage with a registered ID/EX output slot. It decodes the integer ALU instruction classes OP-IMM, OP, LUI and AUIPC, and reads the register file. It resolves RAW hazards by forwarding from the EX and MEM stages, and interlocks on load-use. It sits between the IF/ID register and EX, and uses a valid/ready handshake on both sides with a flush input for redirects.

## Interface
- XLEN, 32, datapath width; immediates sign-extended to XLEN
- FWD_EN, 1, 1: forward from EX/MEM; 0: interlock on any pending EX/MEM write instead
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- if_valid_i  in  1  instruction present on pc_i/inst_i
- pc_i  in  XLEN  instruction address
- inst_i  in  32  instruction word
- id_ready_o  out  1  instruction consumed this cycle (combinational)
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational)
- reg1_addr_o, reg2_addr_o  out  5  inst_i[19:15], inst_i[24:20] (combinational)
- reg1_data_i, reg2_data_i  in  XLEN  regfile read data, same cycle
- ex_wreg_i, ex_wd_i[4:0], ex_wdata_i[XLEN], ex_is_load_i  in  EX-stage write-back info
- mem_wreg_i, mem_wd_i[4:0], mem_wdata_i[XLEN]  in  MEM-stage write-back info
- flush_i  in  1  discard slot and current input
- ex_ready_i  in  1  EX accepts slot
- ex_valid_o  out  1  slot holds an instruction
- aluop_o  out  4  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, NOP 15
- reg1_o, reg2_o  out  XLEN  ALU operands
- wreg_o  out  1  write rd
- wd_o  out  5  rd
- pc_o  out  XLEN  pc of slot instruction
- illegal_o  out  1  slot instruction has unsupported opcode/funct

## Operation
- Decode, combinational on inst_i:
  - OP-IMM (0010011): reg1 = rs1; reg2 = sign-extended I-immediate. For SLLI/SRLI/SRAI, reg2 = zero-extended inst[24:20]. SRAI requires funct7 = 0100000; SLLI/SRLI require 0000000.
  - OP (0110011): reg1 = rs1, reg2 = rs2. funct7 0100000 is valid only with ADD→SUB and SRL→SRA. Otherwise funct7 must be 0000000.
  - LUI: ADD, reg1 = 0, reg2 = {inst[31:12], 12'b0}.
  - AUIPC: ADD, reg1 = pc_i, reg2 = {inst[31:12], 12'b0}.
- Any other encoding is illegal: aluop NOP, wreg 0, illegal 1. It is still loaded as a valid slot.
- wreg = 0 whenever rd = x0.
- Read enables are 1 only for sources actually used.
- Operand source, per enabled read with address a:
  - a = 0 → 0.
  - Else EX match (ex_wreg_i && ex_wd_i = a) → ex_wdata_i.
  - Else MEM match → mem_wdata_i.
  - Else regfile data.
  - EX has priority over MEM.
- hazard (FWD_EN = 1) = if_valid_i && ex_is_load_i && ex_wreg_i && ex_wd_i ≠ 0 && ex_wd_i matches an enabled source.
- hazard (FWD_EN = 0) = an enabled nonzero source matches any EX or MEM pending write. No forwarding muxes are instantiated.
- Slot is EMPTY (ex_valid_o = 0) or FULL. Priority on each edge:
  1. flush_i → slot becomes EMPTY; aluop_o = NOP, wreg_o = 0, illegal_o = 0.
  2. FULL && !ex_ready_i → hold all outputs unchanged.
  3. if_valid_i && !hazard → load decoded instruction, FULL.
  4. Otherwise → bubble: EMPTY, aluop NOP, wreg 0, illegal 0.
- id_ready_o = flush_i || (!hazard && (!ex_valid_o || ex_ready_i)). An instruction presented during flush_i is dropped.
- Operands are captured at load and are not re-forwarded while held.

## Timing
- Reset (asynchronous assert, synchronous release): ex_valid_o 0, aluop_o 15, reg1_o/reg2_o/pc_o 0, wreg_o 0, wd_o 0, illegal_o 0.
- Latency: 1 cycle, inst_i at edge N → outputs valid after edge N.
- Throughput: 1 instruction/cycle without hazards.
- Load-use costs exactly 1 bubble with FWD_EN = 1. With FWD_EN = 0, interlock lasts until the producer leaves MEM.
- flush_i together with a hazard or backpressure: flush wins.
- Reset mid-hold drops the slot.

## Test plan
- Reset low, then ORI x1,x0,0xFF (0x0FF06093) → next cycle ex_valid_o 1, aluop 8, reg1 0, reg2 0xFF, wd 1, wreg 1.
- ADD x3,x1,x2 (0x002081B3) with ex_wd = 1/ex_wdata = 5 and mem_wd = 2/mem_wdata = 7, regfile returning 0 → reg1 5, reg2 7. Repeat with EX and MEM both targeting x1 → reg1 = ex_wdata.
- ex_is_load_i with ex_wd = 1 and ADD x3,x1,x2 valid → id_ready_o 0 for one cycle, bubble (ex_valid_o 0, aluop 15). Then ADD loads once the load is cleared.
- ex_ready_i low for 3 cycles with slot FULL → outputs stable, id_ready_o 0; issue resumes on the cycle ex_ready_i rises.
- SRAI x6,x1,4 (0x4040D313) → aluop 7, reg2 4. LUI x5,0x12345 (0x123452B7) → reg1 0, reg2 0x12345000. Opcode 0x7F → illegal_o 1, wreg 0.
- flush_i with slot FULL and input valid → id_ready_o 1, next cycle ex_valid_o 0. With FWD_EN = 0, ADD depending on a MEM-pending x2 stalls 1 cycle.
